// File: rtl/conv_window_sched_if.sv
// Handshake and data bundle for conv_window_sched: start/image/filter in, window sums out.
// The master drives start, image, filter and out_ready; the slave (the scheduler) drives the rest.
interface conv_window_sched_if #(
  parameter int IN_DIM   = 5,
  parameter int FILT_DIM = 3,
  parameter int WIDTH    = 4
);
  localparam int SUM_W = 2 * WIDTH + $clog2(FILT_DIM * FILT_DIM);

  logic                              start;
  logic [IN_DIM*IN_DIM*WIDTH-1:0]    image;
  logic [FILT_DIM*FILT_DIM*WIDTH-1:0] filter;
  logic                              busy;
  logic                              out_valid;
  logic                              out_ready;
  logic [SUM_W-1:0]                  out_data;
  logic                              out_last;
  logic                              done;

  modport master (
    output start, image, filter, out_ready,
    input  busy, out_valid, out_data, out_last, done
  );

  modport slave (
    input  start, image, filter, out_ready,
    output busy, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/conv_window_sched.sv
// Window scheduler: latches image/filter, issues every output position row-major, multiplies through a
// MULT_LAT-stage pipe and sums 9 products to a valid/ready stream. Define CONV_RELU_EN to clamp sums at 0.
module conv_window_sched #(
  parameter int FILT_DIM = 3,
  parameter int IN_DIM   = 5,
  parameter int STRIDE   = 1,
  parameter int WIDTH    = 4,
  parameter int MULT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_sched_if.slave bus
);
  localparam int OUT_DIM = (IN_DIM - FILT_DIM) / STRIDE + 1;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int NPROD   = FILT_DIM * FILT_DIM;
  localparam int SUM_W   = PROD_W + $clog2(NPROD);
  localparam int NPIX    = IN_DIM * IN_DIM;
  localparam int CNT_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IDX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         orow_q, orow_d, ocol_q, ocol_d;
  logic signed [WIDTH-1:0]  img_q  [NPIX];
  logic signed [WIDTH-1:0]  filt_q [NPROD];
  logic signed [WIDTH-1:0]  win_d  [NPROD];
  logic signed [WIDTH-1:0]  win_q  [NPROD];
  logic                     s0_vld_q, s0_vld_d, s0_last_q, s0_last_d;
  logic signed [PROD_W-1:0] prod_q [MULT_LAT][NPROD];
  logic [MULT_LAT-1:0]      pv_q, pl_q;
  logic signed [SUM_W-1:0]  sum, res;
  logic                     out_valid_q, out_last_q;
  logic signed [SUM_W-1:0]  out_data_q;
  logic                     adv, load, last_pos, issue;

  // Single stall enable: everything freezes while a result sits unaccepted.
  assign adv      = !(out_valid_q && !bus.out_ready);
  assign load     = (state_q == ST_IDLE) && bus.start;
  assign last_pos = (orow_q == CNT_W'(OUT_DIM - 1)) && (ocol_q == CNT_W'(OUT_DIM - 1));
  assign issue    = (state_q == ST_ISSUE) && adv;

  always_comb begin
    state_d   = state_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    s0_vld_d  = s0_vld_q;
    s0_last_d = s0_last_q;
    if (adv) begin
      s0_vld_d  = issue;
      s0_last_d = issue && last_pos;
    end
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_ISSUE;
      ST_ISSUE: if (adv) begin
        if (last_pos) begin
          state_d = ST_DRAIN;
          orow_d  = '0;
          ocol_d  = '0;
        end else if (ocol_q == CNT_W'(OUT_DIM - 1)) begin
          ocol_d = '0;
          orow_d = orow_q + CNT_W'(1);
        end else begin
          ocol_d = ocol_q + CNT_W'(1);
        end
      end
      ST_DRAIN: if (out_valid_q && bus.out_ready && out_last_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    int base;
    base = int'(orow_q) * STRIDE * IN_DIM + int'(ocol_q) * STRIDE;
    for (int i = 0; i < FILT_DIM; i++) begin
      for (int j = 0; j < FILT_DIM; j++) begin
        win_d[i*FILT_DIM+j] = img_q[IDX_W'(base + i * IN_DIM + j)];
      end
    end
  end

  // Products are sign-extended before summing so the sum cannot overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NPROD; k++) begin
      sum = sum + SUM_W'(prod_q[MULT_LAT-1][k]);
    end
    res = sum;
`ifdef CONV_RELU_EN
    if (sum[SUM_W-1]) res = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      orow_q      <= '0;
      ocol_q      <= '0;
      s0_vld_q    <= 1'b0;
      s0_last_q   <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < NPIX; k++) img_q[k] <= '0;
      for (int k = 0; k < NPROD; k++) begin
        filt_q[k] <= '0;
        win_q[k]  <= '0;
      end
      for (int s = 0; s < MULT_LAT; s++) begin
        for (int k = 0; k < NPROD; k++) prod_q[s][k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      s0_vld_q  <= s0_vld_d;
      s0_last_q <= s0_last_d;
      if (load) begin
        for (int k = 0; k < NPIX; k++) img_q[k] <= bus.image[k*WIDTH +: WIDTH];
        for (int k = 0; k < NPROD; k++) filt_q[k] <= bus.filter[k*WIDTH +: WIDTH];
      end
      if (adv) begin
        for (int k = 0; k < NPROD; k++) begin
          win_q[k]     <= win_d[k];
          prod_q[0][k] <= PROD_W'(win_q[k]) * PROD_W'(filt_q[k]);
        end
        pv_q[0] <= s0_vld_q;
        pl_q[0] <= s0_last_q;
        for (int s = 1; s < MULT_LAT; s++) begin
          pv_q[s] <= pv_q[s-1];
          pl_q[s] <= pl_q[s-1];
          for (int k = 0; k < NPROD; k++) prod_q[s][k] <= prod_q[s-1][k];
        end
        out_valid_q <= pv_q[MULT_LAT-1];
        out_last_q  <= pv_q[MULT_LAT-1] && pl_q[MULT_LAT-1];
        if (pv_q[MULT_LAT-1]) out_data_q <= res;
      end
    end
  end

  assign bus.busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: three instances cover WIDTH=4, WIDTH=8 and STRIDE=2 cases.
module tb_conv_window_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   lat;
  logic [15:0] rdy_pat = 16'b1001_1001_0110_1101;

  int exp_t1[$] = '{9, 9, 9, 9, 9, 9, 9, 9, 9};
`ifdef CONV_RELU_EN
  int exp_t4[$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
  int exp_t4[$] = '{-9, -9, -9, -9, -9, -9, -9, -9, -9};
`endif
  int exp_t2[$] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
  int exp_t5[$] = '{6, 8, 16, 18};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_sched_if #(.IN_DIM(5), .FILT_DIM(3), .WIDTH(4)) if_a ();
  conv_window_sched_if #(.IN_DIM(5), .FILT_DIM(3), .WIDTH(8)) if_b ();
  conv_window_sched_if #(.IN_DIM(5), .FILT_DIM(3), .WIDTH(8)) if_c ();

  conv_window_sched #(.FILT_DIM(3), .IN_DIM(5), .STRIDE(1), .WIDTH(4), .MULT_LAT(1))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  conv_window_sched #(.FILT_DIM(3), .IN_DIM(5), .STRIDE(1), .WIDTH(8), .MULT_LAT(1))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  conv_window_sched #(.FILT_DIM(3), .IN_DIM(5), .STRIDE(2), .WIDTH(8), .MULT_LAT(1))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input bit gl[$], input int exp[$]);
    check($sformatf("%s beat count", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s beat%0d data", tag, i), got[i], exp[i]);
        check($sformatf("%s beat%0d last", tag, i), gl[i], (i == exp.size() - 1) ? 1 : 0);
      end
    end
  endtask

  // Accepted-beat capture, sampled on the falling edge ahead of the accepting rising edge.
  int   q_a[$], q_b[$], q_c[$];
  bit   ql_a[$], ql_b[$], ql_c[$];
  bit   done_a = 0, done_b = 0, done_c = 0;
  int   done_cyc_a = 0, last_cyc_a = 0;
  logic done_busy_a = 1'b0, done_vld_a = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (if_a.out_valid && if_a.out_ready) begin
        q_a.push_back(int'($signed(if_a.out_data)));
        ql_a.push_back(if_a.out_last);
        if (if_a.out_last) last_cyc_a = cyc;
      end
      if (if_a.done) begin
        done_a      = 1;
        done_cyc_a  = cyc;
        done_busy_a = if_a.busy;
        done_vld_a  = if_a.out_valid;
      end
    end
  end

  logic stall_b = 1'b0;
  int   prev_b = 0;
  logic prev_lb = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_b) begin
        check("t3 stalled valid held", if_b.out_valid, 1);
        check("t3 stalled data held", $signed(if_b.out_data), prev_b);
        check("t3 stalled last held", if_b.out_last, prev_lb);
      end
      stall_b = if_b.out_valid && !if_b.out_ready;
      prev_b  = int'($signed(if_b.out_data));
      prev_lb = if_b.out_last;
      if (if_b.out_valid && if_b.out_ready) begin
        q_b.push_back(int'($signed(if_b.out_data)));
        ql_b.push_back(if_b.out_last);
      end
      if (if_b.done) begin
        done_b = 1;
        check("b done without valid", if_b.out_valid, 0);
      end
    end else begin
      stall_b = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_c.out_valid && if_c.out_ready) begin
        q_c.push_back(int'($signed(if_c.out_data)));
        ql_c.push_back(if_c.out_last);
      end
      if (if_c.done) done_c = 1;
    end
  end

  initial begin
    if_a.start = 0; if_a.image = '0; if_a.filter = '0; if_a.out_ready = 1;
    if_b.start = 0; if_b.image = '0; if_b.filter = '0; if_b.out_ready = 1;
    if_c.start = 0; if_c.image = '0; if_c.filter = '0; if_c.out_ready = 1;

    // Reset values
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst busy", if_a.busy, 0);
    check("rst out_valid", if_a.out_valid, 0);
    check("rst out_data", if_a.out_data, 0);
    check("rst out_last", if_a.out_last, 0);
    check("rst done", if_a.done, 0);

    // T1: all ones, latency and done timing; inputs cleared after start to prove latching
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) if_a.image[k*4 +: 4] = 4'd1;
    for (int k = 0; k < 9; k++) if_a.filter[k*4 +: 4] = 4'd1;
    if_a.start = 1;
    @(posedge clk); #1;
    if_a.start = 0; if_a.image = '0; if_a.filter = '0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (if_a.out_valid) begin
        lat = n;
        break;
      end
    end
    check("t1 issue-to-valid latency", lat, 3);
    check("t1 busy during pass", if_a.busy, 1);
    for (int i = 0; i < 100 && !done_a; i++) @(posedge clk);
    check("t1 done seen", done_a, 1);
    check("t1 done one cycle after last", done_cyc_a - last_cyc_a, 1);
    check("t1 busy low at done", done_busy_a, 0);
    check("t1 valid low at done", done_vld_a, 0);
    check_seq("t1", q_a, ql_a, exp_t1);
    q_a.delete(); ql_a.delete(); done_a = 0;

    // T4: filter all -1
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) if_a.image[k*4 +: 4] = 4'd1;
    for (int k = 0; k < 9; k++) if_a.filter[k*4 +: 4] = 4'hF;
    if_a.start = 1;
    @(posedge clk); #1 if_a.start = 0;
    for (int i = 0; i < 100 && !done_a; i++) @(posedge clk);
    check("t4 done seen", done_a, 1);
    check_seq("t4", q_a, ql_a, exp_t4);
    q_a.delete(); ql_a.delete(); done_a = 0;

    // T6: abort after 4 beats, then a fresh pass with a start pulse while busy
    @(posedge clk); #1;
    if_a.start = 1;
    @(posedge clk); #1 if_a.start = 0;
    for (int i = 0; i < 100 && q_a.size() < 4; i++) @(posedge clk);
    check("t6 four beats before abort", q_a.size(), 4);
    #1 rst = 1;
    #1;
    check("t6 abort busy", if_a.busy, 0);
    check("t6 abort out_valid", if_a.out_valid, 0);
    check("t6 abort out_data", if_a.out_data, 0);
    check("t6 abort out_last", if_a.out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    q_a.delete(); ql_a.delete(); done_a = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) if_a.filter[k*4 +: 4] = 4'd1;
    if_a.start = 1;
    @(posedge clk); #1 if_a.start = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 25; k++) if_a.image[k*4 +: 4] = 4'd2;
    if_a.start = 1;
    @(posedge clk); #1 if_a.start = 0;
    for (int i = 0; i < 100 && !done_a; i++) @(posedge clk);
    check("t6 done seen", done_a, 1);
    check_seq("t6", q_a, ql_a, exp_t1);
    repeat (3) @(posedge clk);
    #1 check("t6 idle after pass", if_a.busy, 0);

    // T2: ramp image, centre-tap filter
    @(posedge clk); #1;
    for (int k = 0; k < 25; k++) begin
      if_b.image[k*8 +: 8] = 8'(k);
      if_c.image[k*8 +: 8] = 8'(k);
    end
    if_b.filter = '0; if_b.filter[4*8 +: 8] = 8'd1;
    if_c.filter = '0; if_c.filter[4*8 +: 8] = 8'd1;
    if_b.start = 1;
    @(posedge clk); #1 if_b.start = 0;
    for (int i = 0; i < 100 && !done_b; i++) @(posedge clk);
    check("t2 done seen", done_b, 1);
    check_seq("t2", q_b, ql_b, exp_t2);
    q_b.delete(); ql_b.delete(); done_b = 0;

    // T3: same stimulus under a fixed irregular ready pattern
    @(posedge clk); #1;
    if_b.out_ready = rdy_pat[0];
    if_b.start = 1;
    @(posedge clk); #1 if_b.start = 0;
    for (int i = 0; i < 300 && !done_b; i++) begin
      @(posedge clk);
      #1 if_b.out_ready = rdy_pat[i % 16];
    end
    if_b.out_ready = 1;
    check("t3 done seen", done_b, 1);
    check_seq("t3", q_b, ql_b, exp_t2);

    // T5: stride 2
    @(posedge clk); #1;
    if_c.start = 1;
    @(posedge clk); #1 if_c.start = 0;
    for (int i = 0; i < 100 && !done_c; i++) @(posedge clk);
    check("t5 done seen", done_c, 1);
    check_seq("t5", q_c, ql_c, exp_t5);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
